tt_sweep: RTL

TT_SWEEP -- requirements
Module: tt_sweep

---
 rtl/tt_sweep_pkg.sv | 29 ++
 rtl/tt_mem.sv | 42 ++++
 rtl/tt_sweep.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_pkg
// Description : Shared definitions for the truth-table sweep block: default
//               geometry, sequencer state encoding and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_sweep_pkg;

    // Default geometry: 4-bit stimulus, 4-bit response, one settle cycle.
    localparam int C_NIN_DEFAULT    = 4;
    localparam int C_NOUT_DEFAULT   = 4;
    localparam int C_SETTLE_DEFAULT = 1;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a down-counter that must hold n-1. Never narrower than one
    // bit, so that SETTLE=1 still yields a legal (constant-zero) counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_mem.sv
`default_nettype none
// ============================================================================
// Module      : tt_mem
// Description : Expected-response table, 2^AW words of DW bits. One
//               synchronous write port and one asynchronous read port.
//               Contents are intentionally not reset.
// Ports       : clk      - clock
//               wr_en    - write strobe (already qualified by the caller)
//               wr_addr  - write index
//               wr_data  - write word
//               rd_addr  - read index
//               rd_data  - read word (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module tt_mem
    import tt_sweep_pkg::*;
#(
    parameter int AW = C_NIN_DEFAULT,
    parameter int DW = C_NOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int C_DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [0:C_DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/tt_sweep.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep
// Description : Exhaustive truth-table checker. On start, drives every
//               stimulus vector 0 .. 2^NIN-1 to the logic under test, waits
//               SETTLE cycles per vector, samples the response and compares
//               it with a preloaded expected table. Reports mismatch count,
//               first failing index and an overall pass flag.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               wr_en/wr_addr/wr_data - expected-table load (IDLE only)
//               start              - sweep request (IDLE only)
//               resp               - response from the logic under test
//               stim               - registered stimulus to the logic under test
//               busy / done        - sweep running / one-cycle completion pulse
//               pass               - last completed sweep had no mismatch
//               err_count          - mismatch count of current/last sweep
//               fail_valid/fail_idx - first mismatching stimulus index
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int NIN    = C_NIN_DEFAULT,
    parameter int NOUT   = C_NOUT_DEFAULT,
    parameter int SETTLE = C_SETTLE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [NIN-1:0]  wr_addr,
    input  logic [NOUT-1:0] wr_data,
    input  logic            start,
    input  logic [NOUT-1:0] resp,
    output logic [NIN-1:0]  stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [NIN:0]    err_count,
    output logic            fail_valid,
    output logic [NIN-1:0]  fail_idx
);

    localparam int                 C_CNT_W   = cnt_width(SETTLE);
    localparam logic [C_CNT_W-1:0] C_RELOAD  = C_CNT_W'(SETTLE - 1);
    localparam logic [NIN-1:0]     C_LAST    = '1;
    // 2^NIN: every vector mismatching. NIN+1 bits hold it exactly.
    localparam logic [NIN:0]       C_ERR_MAX = {1'b1, {NIN{1'b0}}};

    state_t             r_state;
    state_t             w_next;
    logic [C_CNT_W-1:0] r_settle;
    logic [NIN-1:0]     r_stim;
    logic [NIN:0]       r_err;
    logic               r_pass;
    logic               r_fail_valid;
    logic [NIN-1:0]     r_fail_idx;

    logic [NOUT-1:0]    w_expected;
    logic               w_accept;
    logic               w_cmp;
    logic               w_last;
    logic               w_mismatch;
    logic [NIN:0]       w_err_next;
    logic               w_mem_we;

    // ------------------------------------------------------------------
    // Expected table. Loads are only honoured while idle so a sweep always
    // checks against a stable table. A load coinciding with start lands on
    // the same edge the sweep begins, well before its first compare.
    // ------------------------------------------------------------------
    assign w_mem_we = wr_en && (r_state == IDLE);

    tt_mem #(
        .AW (NIN),
        .DW (NOUT)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_mem_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (r_stim),
        .rd_data (w_expected)
    );

    // ------------------------------------------------------------------
    // Compare qualification
    // ------------------------------------------------------------------
    assign w_accept   = (r_state == IDLE) && start;
    assign w_cmp      = (r_state == RUN) && (r_settle == '0);
    assign w_last     = (r_stim == C_LAST);
    assign w_mismatch = w_cmp && (resp != w_expected);
    // The count cannot exceed 2^NIN by construction; the guard keeps it
    // from ever wrapping should that invariant be broken.
    assign w_err_next = (w_mismatch && (r_err != C_ERR_MAX)) ? r_err + 1'b1 : r_err;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_cmp && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stimulus, settle counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle     <= '0;
            r_stim       <= '0;
            r_err        <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
        end else if (w_accept) begin
            r_settle     <= C_RELOAD;
            r_stim       <= '0;
            r_err        <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_cmp) begin
                r_err <= w_err_next;
                if (w_mismatch && !r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_idx   <= r_stim;
                end
                if (w_last) begin
                    // Pass is resolved here, including the final compare,
                    // so it is already valid during the DONE cycle.
                    r_stim <= '0;
                    r_pass <= (w_err_next == '0);
                end else begin
                    r_stim   <= r_stim + 1'b1;
                    r_settle <= C_RELOAD;
                end
            end else begin
                r_settle <= r_settle - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stim       = r_stim;
    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_idx   = r_fail_idx;

endmodule
`default_nettype wire
